// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding
// and the bridge base address at which the controller is mapped.
package irq_ctrl_pkg;

    localparam logic [1:0] IC_MASK = 2'd0;
    localparam logic [1:0] IC_PEND = 2'd1;
    localparam logic [1:0] IC_STAT = 2'd2;
    localparam logic [1:0] IC_EOI  = 2'd3;

    localparam logic [31:0] IC_BASE_ADDR = 32'h0000_7F20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } ic_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder returning {valid, id} for a request vector.
module irq_prio_enc #(
    parameter int N    = 6,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding CP0 HWInt: edge capture, mask, fixed priority and EOI.
// Optional nested preemption (one level) is enabled by defining IRQ_CTRL_PREEMPT_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:2]      Addr,
    input  logic             IcWrite,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    input  logic             int_ack
);

    ic_state_t        state, state_next;
    logic [N_SRC-1:0] mask, pending, prev_irq;
    logic [N_SRC-1:0] eligible, rise, w1c, ack_clr;
    logic [ID_W-1:0]  cur_id, sel_id, pre_id, saved_id;
    logic             sel_vld, pre_vld, saved_vld;
    logic             wr_mask, wr_pend, wr_eoi;
    logic             ack_req, ack_pre, eoi_pop, eoi_idle;
    logic             unused_bits;

    assign unused_bits = ^{Addr[31:4], Din[31:N_SRC]};

    assign wr_mask  = IcWrite && (Addr[3:2] == IC_MASK);
    assign wr_pend  = IcWrite && (Addr[3:2] == IC_PEND);
    assign wr_eoi   = IcWrite && (Addr[3:2] == IC_EOI);

    assign eligible = pending & mask;
    assign rise     = irq_in & ~prev_irq;
    assign w1c      = wr_pend ? Din[N_SRC-1:0] : '0;
    assign ack_clr  = (ack_req || ack_pre) ? (N_SRC'(1) << int_id) : '0;

    irq_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_sel (
        .req   (eligible),
        .valid (sel_vld),
        .id    (sel_id)
    );

`ifdef IRQ_CTRL_PREEMPT_EN
    logic [N_SRC-1:0] below;

    // Only sources strictly higher in priority than the one in service may preempt.
    always_comb begin
        below = '0;
        for (int i = 0; i < N_SRC; i++) begin
            below[i] = (i < int'(cur_id));
        end
    end

    irq_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_pre (
        .req   (eligible & below),
        .valid (pre_vld),
        .id    (pre_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            saved_vld <= 1'b0;
        end else if (ack_pre) begin
            saved_vld <= 1'b1;
        end else if (eoi_pop) begin
            saved_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ack_pre) begin
            saved_id <= cur_id;
        end
    end
`else
    assign pre_vld   = 1'b0;
    assign pre_id    = '0;
    assign saved_vld = 1'b0;
    assign saved_id  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        int_req    = 1'b0;
        int_id     = '0;
        ack_req    = 1'b0;
        ack_pre    = 1'b0;
        eoi_pop    = 1'b0;
        eoi_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // The request follows the encoder live, so a late higher-priority edge wins.
                int_req = sel_vld;
                int_id  = sel_id;
                if (!sel_vld) begin
                    state_next = IDLE;
                end else if (int_ack) begin
                    ack_req    = 1'b1;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    if (saved_vld) begin
                        eoi_pop = 1'b1;
                    end else begin
                        eoi_idle   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (pre_vld && !saved_vld) begin
                    int_req = 1'b1;
                    int_id  = pre_id;
                    ack_pre = int_ack;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            pending  <= '0;
            prev_irq <= '0;
            cur_id   <= '0;
        end else begin
            prev_irq <= irq_in;
            // A fresh edge overrides any clear aimed at the same bit this cycle.
            pending  <= (pending & ~(w1c | ack_clr)) | rise;
            if (wr_mask) begin
                mask <= Din[N_SRC-1:0];
            end
            if (ack_req || ack_pre) begin
                cur_id <= int_id;
            end else if (eoi_pop) begin
                cur_id <= saved_id;
            end else if (eoi_idle) begin
                cur_id <= '0;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            IC_MASK: Dout = 32'(mask);
            IC_PEND: Dout = 32'(pending);
            IC_STAT: Dout = {(state == SERVICE), saved_vld, {(30 - ID_W){1'b0}}, cur_id};
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic against a
// behavioural model of pending bits, priority and the request/service life cycle.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

`ifdef IRQ_CTRL_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        IcWrite;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  irq_in;
    logic        int_req;
    logic [2:0]  int_id;
    logic        int_ack;

    int checks = 0;
    int errors = 0;
    int irq_v  = 0;

    // Model: 0 idle, 1 requesting, 2 in service
    int m_prev, m_pend, m_mask, m_phase, m_cur, m_sv, m_saved;

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .IcWrite (IcWrite),
        .Din     (Din),
        .Dout    (Dout),
        .irq_in  (irq_in),
        .int_req (int_req),
        .int_id  (int_id),
        .int_ack (int_ack)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input int v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_mask = 0; m_phase = 0;
        m_cur = 0; m_sv = 0; m_saved = 0;
    endtask

    task automatic expect_out(input bit wr, input int addr, output bit req, output int id,
                              output logic [31:0] rd);
        int lo;
        lo  = lowest(m_pend & m_mask);
        req = 1'b0;
        id  = lo;
        if (m_phase == 1) req = (lo >= 0);
        if (m_phase == 2) req = PRE && !m_sv && lo >= 0 && lo < m_cur && !(wr && addr == 3);
        case (addr)
            0: rd = m_mask;
            1: rd = m_pend;
            2: rd = ((m_phase == 2) ? 32'h8000_0000 : 0) | (m_sv ? 32'h4000_0000 : 0) | m_cur;
            default: rd = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic rd(input int addr, output logic [31:0] val);
        Addr = 30'(addr); IcWrite = 1'b0; int_ack = 1'b0;
        #1 val = Dout;
    endtask

    task automatic cyc(input bit wr, input int addr, input logic [31:0] din, input bit ack);
        bit req; int id; logic [31:0] erd; int lo; int rise; int clr;
        Addr = 30'(addr); IcWrite = wr; Din = din; int_ack = ack; irq_in = 6'(irq_v);
        #1;
        expect_out(wr, addr, req, id, erd);
        chk("int_req", 32'(int_req), 32'(req));
        if (req) chk("int_id", 32'(int_id), 32'(id));
        chk("dout", Dout, erd);
        @(posedge clk);
        lo = lowest(m_pend & m_mask);
        rise = irq_v & ~m_prev & 'h3F;
        clr = (wr && addr == 1) ? (din & 'h3F) : 0;
        case (m_phase)
            0: if (lo >= 0) m_phase = 1;
            1: if (lo < 0) m_phase = 0;
               else if (ack) begin m_cur = lo; clr |= (1 << lo); m_phase = 2; end
            2: if (wr && addr == 3) begin
                   if (m_sv) begin m_cur = m_saved; m_sv = 0; end
                   else begin m_phase = 0; m_cur = 0; end
               end else if (req && ack) begin
                   m_saved = m_cur; m_sv = 1; m_cur = lo; clr |= (1 << lo);
               end
            default: ;
        endcase
        m_pend = (m_pend & ~clr) | rise;
        if (wr && addr == 0) m_mask = din & 'h3F;
        m_prev = irq_v;
        #1; IcWrite = 1'b0; int_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
    endtask

    task automatic pulse(input int bits);
        irq_v = bits; cyc(0, 1, 0, 0);
        irq_v = 0;
    endtask

    task automatic drain();
        logic [31:0] v;
        cyc(1, 3, 0, 0); cyc(1, 3, 0, 0); cyc(1, 1, 32'hFF, 0);
        idle(2);
        rd(2, v); chk("drain_stat", v, 0);
        chk("drain_req", 32'(int_req), 0);
    endtask

    initial begin
        logic [31:0] v;
        bit req; int id; logic [31:0] erd;
        reset = 1'b1; Addr = '0; IcWrite = 1'b0; Din = '0; irq_in = '0; int_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin rd(a, v); chk("reset_reg", v, 0); end
        chk("reset_req", 32'(int_req), 0);

        // Basic request, ack, EOI
        cyc(1, 0, 32'h3F, 0);
        pulse(32'h04);
        rd(1, v); chk("pend_after_edge", v, 32'h04);
        chk("no_req_yet", 32'(int_req), 0);
        idle(1);
        chk("req_t2", 32'(int_req), 1); chk("id_t2", 32'(int_id), 2);
        cyc(0, 1, 0, 1);
        rd(1, v); chk("pend_acked", v, 0);
        rd(2, v); chk("stat_busy", v, 32'h8000_0002);
        cyc(1, 3, 0, 0);
        rd(2, v); chk("stat_eoi", v, 0);
        idle(1); chk("req_after_eoi", 32'(int_req), 0);

        // Simultaneous edges: lowest index first, the other after EOI
        pulse(32'h12); idle(1);
        chk("simul_id", 32'(int_id), 1);
        cyc(0, 1, 0, 1); cyc(1, 3, 0, 0);
        chk("eoi_t1_req", 32'(int_req), 0);
        idle(1);
        chk("next_req", 32'(int_req), 1); chk("next_id", 32'(int_id), 4);
        cyc(0, 1, 0, 1); cyc(1, 3, 0, 0);
        idle(1);

        // Higher-priority arrival while requesting
        pulse(32'h08); idle(1);
        chk("req3_id", 32'(int_id), 3);
        pulse(32'h01);
        chk("swap_id", 32'(int_id), 0);
        cyc(0, 1, 0, 1);
        rd(1, v); chk("keep_bit3", v, 32'h08);
        rd(2, v); chk("stat_id0", v, 32'h8000_0000);
        drain();

        // Masked source, unmask, W1C back to idle
        cyc(1, 0, 32'h3E, 0);
        pulse(32'h01);
        rd(1, v); chk("masked_pend", v, 32'h01);
        idle(1); chk("masked_noreq", 32'(int_req), 0);
        cyc(1, 0, 32'h3F, 0); idle(1);
        chk("unmask_req", 32'(int_req), 1); chk("unmask_id", 32'(int_id), 0);
        cyc(1, 1, 32'h01, 0);
        chk("w1c_idle_req", 32'(int_req), 0);
        idle(1); rd(2, v); chk("w1c_idle_stat", v, 0);

        // Edge beats same-cycle W1C; level held high does not re-set
        irq_v = 32'h20; cyc(1, 1, 32'h20, 0);
        rd(1, v); chk("set_beats_clr", v, 32'h20);
        cyc(1, 1, 32'h20, 0);
        rd(1, v); chk("level_no_reset", v, 0);
        idle(2); rd(1, v); chk("level_hold", v, 0);
        irq_v = 0; drain();

        // Reset during service
        pulse(32'h04); idle(1); cyc(0, 1, 0, 1);
        rd(2, v); chk("svc_before_rst", v, 32'h8000_0002);
        reset = 1'b1; @(posedge clk); model_reset(); #1 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin rd(a, v); chk("rst_mid_reg", v, 0); end
        chk("rst_mid_req", 32'(int_req), 0);
        cyc(1, 0, 32'h3F, 0);

        if (PRE) begin
            pulse(32'h10); idle(1); cyc(0, 1, 0, 1);
            rd(2, v); chk("pre_svc4", v, 32'h8000_0004);
            pulse(32'h02);
            chk("pre_req", 32'(int_req), 1); chk("pre_id", 32'(int_id), 1);
            cyc(0, 1, 0, 1);
            rd(2, v); chk("pre_nested", v, 32'hC000_0001);
            cyc(1, 3, 0, 0);
            rd(2, v); chk("pre_pop", v, 32'h8000_0004);
            cyc(1, 3, 0, 0);
            rd(2, v); chk("pre_idle", v, 0);
            idle(1);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int addr; bit wr; bit ack; logic [31:0] din;
            if ($urandom_range(0, 3) == 0) irq_v = $urandom_range(0, 63);
            wr   = ($urandom_range(0, 7) == 0);
            addr = $urandom_range(0, 3);
            din  = $urandom;
            if (wr && addr == 0 && $urandom_range(0, 1) == 1) din = 32'h3F;
            expect_out(wr, addr, req, id, erd);
            ack  = req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cyc(wr, addr, din, ack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
